// File: rtl/disp_event_flags_if.sv
// ============================================================================
// Module   : disp_event_flags_if
// Brief    : Event inputs, CPU controls and flag/counter outputs of the
//            display event flag block.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface disp_event_flags_if #(
    parameter int NCH   = 2,
    parameter int CNT_W = 16
);
    logic [NCH-1:0]   EVT_IN;
    logic [NCH-1:0]   EDGE_SEL;
    logic [NCH-1:0]   IRQ_EN;
    logic [NCH-1:0]   CLR;
    logic             CNT_CLR;
    logic [NCH-1:0]   FLAG;
    logic [NCH-1:0]   OVRUN;
    logic             IRQ;
    logic [CNT_W-1:0] FRAME_CNT;

    // Master is the timing generator / register file side; slave is the flag block.
    modport master (
        output EVT_IN, EDGE_SEL, IRQ_EN, CLR, CNT_CLR,
        input  FLAG, OVRUN, IRQ, FRAME_CNT
    );

    modport slave (
        input  EVT_IN, EDGE_SEL, IRQ_EN, CLR, CNT_CLR,
        output FLAG, OVRUN, IRQ, FRAME_CNT
    );
endinterface

`default_nettype wire

// File: rtl/disp_event_flags.sv
// ============================================================================
// Module   : disp_event_flags
// Brief    : Multi-channel synchronised edge detector with sticky CPU-cleared
//            flags, overrun flags, combined IRQ and a channel-0 frame counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module disp_event_flags #(
    parameter int NCH         = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  wire logic         ACLK,
    input  wire logic         ARESETN,
    disp_event_flags_if.slave bus
);

    logic [SYNC_STAGES:0] warm_q;
    logic                 w_warm;
    logic [NCH-1:0]       w_evt;

    logic [NCH-1:0]       flag_q;
    logic [NCH-1:0]       flag_d;
    logic [NCH-1:0]       ovrun_q;
    logic [NCH-1:0]       ovrun_d;
    logic                 irq_q;
    logic                 irq_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_d;

    // The chains reset to 0, so a high input would look like a rising edge
    // while they fill; events stay masked until the warm-up chain is full.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            warm_q <= '0;
        end else begin
            warm_q <= {warm_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign w_warm = warm_q[SYNC_STAGES];

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   dly_q;
        logic                   w_rise;
        logic                   w_fall;

        always_ff @(posedge ACLK or negedge ARESETN) begin
            if (!ARESETN) begin
                sync_q <= '0;
                dly_q  <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], bus.EVT_IN[i]};
                dly_q  <= sync_q[SYNC_STAGES-1];
            end
        end

        assign w_rise   =  sync_q[SYNC_STAGES-1] & ~dly_q;
        assign w_fall   = ~sync_q[SYNC_STAGES-1] &  dly_q;
        assign w_evt[i] = (bus.EDGE_SEL[i] ? w_rise : w_fall) & w_warm;
    end

    always_comb begin
        // A new event beats a simultaneous clear so no event is ever lost.
        flag_d  = w_evt | (flag_q & ~bus.CLR);
        ovrun_d = (w_evt & flag_q & ~bus.CLR) | (ovrun_q & ~bus.CLR);
        irq_d   = |(flag_q & bus.IRQ_EN);

        cnt_d = cnt_q;
        if (bus.CNT_CLR) begin
            cnt_d = w_evt[0] ? CNT_W'(1) : '0;
        end else if (w_evt[0]) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            flag_q  <= '0;
            ovrun_q <= '0;
            irq_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            flag_q  <= flag_d;
            ovrun_q <= ovrun_d;
            irq_q   <= irq_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.FLAG      = flag_q;
    assign bus.OVRUN     = ovrun_q;
    assign bus.IRQ       = irq_q;
    assign bus.FRAME_CNT = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_disp_event_flags.sv
// ============================================================================
// Module   : tb_disp_event_flags
// Brief    : Self-checking bench for disp_event_flags (NCH=2, SYNC_STAGES=2,
//            CNT_W=4) using a per-cycle stimulus table and expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_disp_event_flags;

    localparam int NCH         = 2;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_W       = 4;

    typedef struct packed {
        logic [1:0] evt;
        logic [1:0] clr;
        logic       cc;
        logic [1:0] esel;
        logic [1:0] ien;
    } stim_t;

    typedef struct packed {
        logic [1:0] flag;
        logic [1:0] ovr;
        logic       irq;
        logic [3:0] cnt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    stim_t stim_q[$];
    exp_t  sb[$];

    disp_event_flags_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    disp_event_flags #(
        .NCH         (NCH),
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W)
    ) u_dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [1:0] evt, input logic [1:0] clr, input logic cc,
                            input logic [1:0] esel, input logic [1:0] ien,
                            input logic [1:0] flag, input logic [1:0] ovr, input logic irq,
                            input logic [3:0] cnt);
        stim_t s;
        exp_t  e;
        s = '{evt: evt, clr: clr, cc: cc, esel: esel, ien: ien};
        e = '{flag: flag, ovr: ovr, irq: irq, cnt: cnt};
        stim_q.push_back(s);
        sb.push_back(e);
    endtask

    task automatic apply(input stim_t s);
        bus.EVT_IN   = s.evt;
        bus.CLR      = s.clr;
        bus.CNT_CLR  = s.cc;
        bus.EDGE_SEL = s.esel;
        bus.IRQ_EN   = s.ien;
    endtask

    task automatic test_reset();
        stim_t s;
        exp_t  e;
        int    row;
        rst_n = 1'b0;
        apply('{evt: 2'b01, clr: 2'b00, cc: 1'b0, esel: 2'b11, ien: 2'b00});
        repeat (3) tick();
        checks++;
        if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== 9'd0) begin
            failures++;
            $display("FAIL reset_state: got flag=%b ovrun=%b irq=%b cnt=%0d, want all 0",
                     bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT);
        end
        rst_n = 1'b1;
        // EVT_IN[0] held high through release must not read as a rising edge.
        for (int n = 0; n < 10; n++)
            push_row(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL warmup row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_falling_edge();
        stim_t s;
        exp_t  e;
        int    row;
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b01, 2'b00, 1'b1, 4'd1);
        push_row(2'b00, 2'b01, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b1, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 4'd1);
        // Same edge with the interrupt disabled: flag sets, IRQ stays low.
        push_row(2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
        push_row(2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
        push_row(2'b01, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b01, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL falling_edge row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_clear_collision();
        stim_t s;
        exp_t  e;
        int    row;
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b10, 1'b0, 2'b11, 2'b10, 2'b10, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b10, 2'b10, 2'b00, 1'b1, 4'd2);
        push_row(2'b10, 2'b10, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b1, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b10, 2'b00, 2'b00, 1'b0, 4'd2);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL clear_collision row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_overrun();
        stim_t s;
        exp_t  e;
        int    row;
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b00, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 4'd2);
        push_row(2'b10, 2'b00, 1'b0, 2'b11, 2'b00, 2'b10, 2'b10, 1'b0, 4'd2);
        push_row(2'b10, 2'b10, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd2);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL overrun row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        int    row;
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd2);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 4'd3);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 4'd3);
        push_row(2'b11, 2'b01, 1'b0, 2'b11, 2'b11, 2'b10, 2'b00, 1'b1, 4'd3);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b10, 2'b00, 1'b1, 4'd3);
        push_row(2'b11, 2'b10, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b1, 4'd3);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        // Flipping edge polarity on settled inputs must not create an event.
        push_row(2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        push_row(2'b00, 2'b00, 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd3);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL back_to_back row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_counter_wrap();
        stim_t      s;
        exp_t       e;
        int         row;
        logic       ef;
        logic [3:0] ec;
        ef = 1'b0;
        ec = 4'd3;
        // 13 more frame events take the 4-bit counter from 3 through 15 to 0;
        // CLR on each event edge keeps FLAG[0] set without an overrun.
        for (int n = 0; n < 13; n++) begin
            push_row(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, {1'b0, ef}, 2'b00, 1'b0, ec);
            push_row(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, {1'b0, ef}, 2'b00, 1'b0, ec);
            ef = 1'b1;
            ec = ec + 4'd1;
            push_row(2'b00, 2'b01, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, ec);
            push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, ec);
        end
        push_row(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0);
        push_row(2'b01, 2'b00, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b01, 1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 4'd1);
        push_row(2'b00, 2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b01, 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 4'd0);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL counter row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    task automatic test_async_reset();
        stim_t s;
        exp_t  e;
        int    row;
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 4'd1);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 4'd1);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL async_setup row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end

        // Assert reset mid-cycle, well away from any rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== 9'd0) begin
            failures++;
            $display("FAIL async_reset: got flag=%b ovrun=%b irq=%b cnt=%0d, want all 0",
                     bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT);
        end
        tick();
        tick();
        rst_n = 1'b1;

        for (int n = 0; n < 10; n++)
            push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b00, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 4'd0);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 4'd1);
        push_row(2'b11, 2'b00, 1'b0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1, 4'd1);
        row = 0;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            apply(s);
            tick();
            e = sb.pop_front();
            checks++;
            if ({bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT} !== e) begin
                failures++;
                $display("FAIL async_rewarm row %0d: got flag=%b ovrun=%b irq=%b cnt=%0d, want flag=%b ovrun=%b irq=%b cnt=%0d",
                         row, bus.FLAG, bus.OVRUN, bus.IRQ, bus.FRAME_CNT, e.flag, e.ovr, e.irq, e.cnt);
            end
            row++;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        test_reset();
        test_falling_edge();
        test_clear_collision();
        test_overrun();
        test_back_to_back();
        test_counter_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/disp_event_flags.md
# disp_event_flags

Parametrised, multi-channel display-event flag block. Each of NCH asynchronous display-timing inputs (VGA_VS, VGA_HS, pixel-domain status, …) is synchronised into ACLK, edge-detected with a per-channel edge polarity, and latched into a sticky flag that the CPU clears. The block also reports missed events (overrun), drives a combined interrupt line and keeps a free-running frame counter on channel 0. It sits between the VGA timing generator and the display register file, and generalises the single-channel VBLANK flag.

## Interface
- NCH, 2: number of event channels (1..16).
- SYNC_STAGES, 2: synchroniser depth (≥2).
- CNT_W, 16: frame-counter width (1..32).

- ACLK  in  1  system clock; all logic is on its rising edge.
- ARESETN  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low).
- EVT_IN  in  NCH  asynchronous event levels; bit 0 is the frame event (VGA_VS).
- EDGE_SEL  in  NCH  per channel: 1 = rising edge is the event, 0 = falling edge is the event. Quasi-static.
- IRQ_EN  in  NCH  per-channel interrupt enable.
- CLR  in  NCH  one-cycle clear pulses for FLAG[i] and OVRUN[i].
- CNT_CLR  in  1  synchronous clear of FRAME_CNT.
- FLAG  out  NCH  sticky event flags.
- OVRUN  out  NCH  sticky: an event arrived while FLAG[i] was already set and not being cleared.
- IRQ  out  1  registered OR of (FLAG & IRQ_EN).
- FRAME_CNT  out  CNT_W  count of channel-0 events; wraps.

## Operation
- Synchroniser, per channel: shift chain s[0..SYNC_STAGES-1], followed by a delay register d that holds the previous s[SYNC_STAGES-1].
- Edge detection: rise = s_last & ~d; fall = ~s_last & d; evt[i] = (EDGE_SEL[i] ? rise : fall) & warm.
- Warm-up: a shift register of SYNC_STAGES+1 bits resets to 0 and shifts in 1 every cycle; warm is its MSB. This suppresses false edges caused by the reset value of the chain, which is all 0.
- Flag update, per channel, in priority order:
  - evt → FLAG=1. Set wins over a simultaneous CLR, so no event is lost.
  - else CLR → FLAG=0.
  - else hold.
- Overrun update, per channel:
  - evt & FLAG & ~CLR → OVRUN=1.
  - else CLR → OVRUN=0.
  - else hold.
  - evt & CLR in the same cycle does not set OVRUN.
- IRQ ← |(FLAG & IRQ_EN). Registered, so it is computed from the current FLAG value.
- FRAME_CNT, in priority order:
  - CNT_CLR & evt[0] → 1.
  - CNT_CLR → 0.
  - evt[0] → FRAME_CNT+1, modulo 2^CNT_W (all-ones wraps to 0).
- Channels are fully independent. Simultaneous events on several channels set all of the corresponding flags in the same cycle.
- A change of EDGE_SEL takes effect on the next evaluated edge; no spurious event is generated by the change itself.

## Timing
- Reset values: FLAG=0, OVRUN=0, IRQ=0, FRAME_CNT=0, synchroniser and d=0, warm chain=0.
- Assertion of ARESETN low clears everything immediately, even mid-operation.
- Deassertion should be synchronous to ACLK, which is supplied externally.
- First possible event: the (SYNC_STAGES+2)th ACLK edge after reset release. Earlier edges are masked by warm.
- Event latency: EVT_IN stable before ACLK edge k is sampled into s[0] at edge k, and FLAG/FRAME_CNT update at edge k+SYNC_STAGES. With the default depth that is 2 cycles.
- IRQ: follows FLAG one cycle later (edge k+SYNC_STAGES+1). It deasserts one cycle after the clearing edge of the last enabled flag.
- CLR: FLAG and OVRUN go to 0 at the edge that samples CLR=1.
- EVT_IN pulses shorter than ~2 ACLK periods may be missed. Guaranteeing capture is the source's responsibility.

## Test plan
- Reset/warm-up: hold EVT_IN[0]=1 through reset release, EDGE_SEL=1 → FLAG stays 0 and FRAME_CNT stays 0 for 10 cycles. No false rising edge.
- Basic falling edge: SYNC_STAGES=2, EDGE_SEL[0]=0, EVT_IN[0] 1→0 before edge k → FLAG[0]=1 at edge k+2, FRAME_CNT=1, IRQ=1 at k+3 when IRQ_EN[0]=1. With IRQ_EN[0]=0, IRQ stays 0.
- Clear/set collision: CLR[1] pulsed in the same cycle as evt[1] → FLAG[1]=1, OVRUN[1]=0. Pulse CLR[1] alone → FLAG[1]=0 on that edge.
- Overrun: two channel-1 events without a clear → OVRUN[1]=1 at the second event's flag edge. CLR[1] → both FLAG[1] and OVRUN[1] return to 0.
- Counter wrap/clear: CNT_W=4, 16 frame events → FRAME_CNT=0 after the 16th. CNT_CLR together with an event → FRAME_CNT=1. CNT_CLR alone → FRAME_CNT=0.
- Async reset mid-operation: ARESETN low while flags and IRQ are set → all outputs 0 without waiting for an ACLK edge. After release, the warm-up masking repeats.
